uart_rx_fifo: RTL



---
 rtl/uart_rx_fifo.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable frame format (data width, parity, stop bits)
// feeding a first-word-fall-through receive FIFO with a valid/ready pop port.
//
// state       | meaning
// S_IDLE      | line idle, waiting for a falling edge on rx_s
// S_START     | timing to mid start bit to reject glitches
// S_DATA      | sampling data bits mid-bit, LSB first
// S_PARITY    | sampling the parity bit
// S_STOP      | sampling stop bit(s); last good sample completes the frame
// S_WAIT_IDLE | after a framing error, hold off until the line returns high
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          input_serial,
    output logic [DATA_BITS-1:0]          output_byte,
    output logic                          byte_valid,
    input  logic                          byte_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          parity_error,
    output logic                          framing_error,
    output logic                          overrun_error
);

    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int IW   = $clog2(DATA_BITS + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;

    localparam logic [CW-1:0]   HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]   FULL_LOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0]   LAST_DATA = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0]   LAST_STOP = IW'(STOP_BITS - 1);
    localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_sync1;
    logic                 r_sync2;
    logic                 w_rx_s;
    logic [CW-1:0]        r_cnt;
    logic [CW-1:0]        w_cnt_nxt;
    logic [IW-1:0]        r_idx;
    logic [IW-1:0]        w_idx_nxt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic                 r_par_bad;
    logic                 w_par_bad_nxt;
    logic                 w_tick;
    logic                 w_done;
    logic                 w_bad;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [CNTW-1:0]      r_count;
    logic                 r_parity_error;
    logic                 r_framing_error;
    logic                 r_overrun_error;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;

    assign w_rx_s = r_sync2;
    assign w_tick = (r_cnt == '0);

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_idx_nxt     = r_idx;
        w_shift_nxt   = r_shift;
        w_par_bad_nxt = r_par_bad;
        w_done        = 1'b0;
        w_bad         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_rx_s) begin
                    w_state_nxt   = S_START;
                    w_cnt_nxt     = HALF_LOAD;
                    w_idx_nxt     = '0;
                    w_par_bad_nxt = 1'b0;
                end
            end
            S_START: begin
                if (w_tick) begin
                    if (w_rx_s) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_DATA;
                        w_cnt_nxt   = FULL_LOAD;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_shift_nxt = {w_rx_s, r_shift[DATA_BITS-1:1]};
                    w_cnt_nxt   = FULL_LOAD;
                    if (r_idx == LAST_DATA) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                    end else begin
                        w_idx_nxt = r_idx + IW'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_PARITY: begin
                if (w_tick) begin
                    w_cnt_nxt   = FULL_LOAD;
                    w_state_nxt = S_STOP;
                    // odd parity expects an odd total, even parity an even total
                    if (PARITY_MODE == 1) begin
                        w_par_bad_nxt = ~((^r_shift) ^ w_rx_s);
                    end else begin
                        w_par_bad_nxt = (^r_shift) ^ w_rx_s;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    w_cnt_nxt = FULL_LOAD;
                    if (!w_rx_s) begin
                        w_bad       = 1'b1;
                        w_state_nxt = S_WAIT_IDLE;
                    end else if (r_idx == LAST_STOP) begin
                        w_done      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_idx_nxt = r_idx + IW'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_WAIT_IDLE: begin
                if (w_rx_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign byte_valid = (r_count != '0);
    assign w_full     = (r_count == FULL_CNT);
    assign w_pop      = byte_valid && byte_ready;
    // a pop in the completion cycle frees the slot the new word needs
    assign w_push     = w_done && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1         <= 1'b1;
            r_sync2         <= 1'b1;
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_idx           <= '0;
            r_shift         <= '0;
            r_par_bad       <= 1'b0;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            r_parity_error  <= 1'b0;
            r_framing_error <= 1'b0;
            r_overrun_error <= 1'b0;
        end else begin
            r_sync1         <= input_serial;
            r_sync2         <= r_sync1;
            r_state         <= w_state_nxt;
            r_cnt           <= w_cnt_nxt;
            r_idx           <= w_idx_nxt;
            r_shift         <= w_shift_nxt;
            r_par_bad       <= w_par_bad_nxt;
            r_parity_error  <= w_done && r_par_bad;
            r_framing_error <= w_bad;
            r_overrun_error <= w_done && w_full && !w_pop;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    assign output_byte   = r_mem[r_rd_ptr];
    assign fifo_count    = r_count;
    assign parity_error  = r_parity_error;
    assign framing_error = r_framing_error;
    assign overrun_error = r_overrun_error;

endmodule
